// File: rtl/usb2_ts_pkg.sv
// usb2_ts_pkg: shared constants and types for the EP3 TS packer.
// Packet geometry, FSM states, capacity helper.
package usb2_ts_pkg;

  localparam int         TS_PKT_LEN = 188;
  localparam logic [7:0] TS_SYNC    = 8'h47;

  typedef enum logic [1:0] {
    ST_WAIT_RDY,
    ST_FILL,
    ST_COMMIT,
    ST_ACK_LOW
  } ts_state_e;

  // Whole packets that fit a buffer addressed by aw bits.
  function automatic int max_pkts(input int aw);
    return ((1 << aw) - 1) / TS_PKT_LEN;
  endfunction

endpackage

// File: rtl/usb2_ts_sync.sv
// usb2_ts_sync: TS packet-start qualification and byte tracking.
// Flags good starts, truncations, malformed starts and last bytes.
module usb2_ts_sync
  import usb2_ts_pkg::*;
(
  input  logic       ext_clk,
  input  logic       reset,
  input  logic [7:0] ts_data,
  input  logic       ts_valid,
  input  logic       ts_start,
  input  logic       abort,
  output logic [7:0] pkt_byte,
  output logic       good_start,
  output logic       truncate,
  output logic       cont,
  output logic       last,
  output logic       err
);

  logic start_v;
  logic mid;

  assign start_v    = ts_valid & ts_start;
  assign mid        = (pkt_byte != 8'd0);
  assign good_start = start_v & (ts_data == TS_SYNC);
  assign truncate   = start_v & mid;
  assign err        = start_v & (mid | (ts_data != TS_SYNC));
  assign cont       = ts_valid & ~ts_start & mid & ~abort;
  assign last       = cont & (pkt_byte == 8'(TS_PKT_LEN - 1));

  // Byte position within the current packet; 0 means between packets.
  always_ff @(posedge ext_clk) begin
    if (reset) begin
      pkt_byte <= 8'd0;
    end else if (good_start) begin
      pkt_byte <= 8'd1;
    end else if (start_v | abort) begin
      pkt_byte <= 8'd0;
    end else if (cont) begin
      pkt_byte <= last ? 8'd0 : pkt_byte + 8'd1;
    end
  end

endmodule

// File: rtl/usb2_ts_packer.sv
// usb2_ts_packer: packs 188-byte TS packets into the EP3 IN buffer.
// Commits on packet count, idle timeout or ready loss.
module usb2_ts_packer #(
  parameter int PKTS_PER_COMMIT = 5,
  parameter int FLUSH_TIMEOUT   = 4096
) (
  input  logic        ext_clk,
  input  logic        reset,
  input  logic [7:0]  ts_data,
  input  logic        ts_valid,
  input  logic        ts_start,
  output logic [10:0] buf_in_addr,
  output logic [7:0]  buf_in_data,
  output logic        buf_in_wren,
  input  logic        buf_in_ready,
  output logic        buf_in_commit,
  output logic [10:0] buf_in_commit_len,
  input  logic        buf_in_commit_ack,
  output logic [15:0] drop_cnt,
  output logic        sync_err
);
  import usb2_ts_pkg::*;

  localparam int PPC_MAX = max_pkts(11);
  localparam int PPC = (PKTS_PER_COMMIT > PPC_MAX) ? PPC_MAX :
                       (PKTS_PER_COMMIT < 1) ? 1 : PKTS_PER_COMMIT;
  localparam int IW = $clog2(FLUSH_TIMEOUT + 2);
  localparam logic [10:0] ROOM_MAX = 11'(2047 - TS_PKT_LEN);
  localparam logic [10:0] ONE_PKT  = 11'(TS_PKT_LEN);

  ts_state_e     state, state_n;
  logic [10:0]   wr_addr, base_addr, eff_addr;
  logic [3:0]    pkt_cnt;
  logic [IW-1:0] idle_cnt;
  logic          wr_active;

  logic [7:0] pkt_byte;
  logic       good_start, truncate, cont, last, err;
  logic       abort_rdy, timeout, abort, mid;
  logic       kill_w, write_ok, wr_byte, pkt_done;
  logic [1:0] drop_inc;
  logic [16:0] drop_sum;

  usb2_ts_sync u_sync (
    .ext_clk    (ext_clk),
    .reset      (reset),
    .ts_data    (ts_data),
    .ts_valid   (ts_valid),
    .ts_start   (ts_start),
    .abort      (abort),
    .pkt_byte   (pkt_byte),
    .good_start (good_start),
    .truncate   (truncate),
    .cont       (cont),
    .last       (last),
    .err        (err)
  );

  // Write/drop decisions for the byte presented this cycle.
  always_comb begin
    abort_rdy = (state == ST_FILL) & ~buf_in_ready;
    timeout   = (FLUSH_TIMEOUT != 0) & (state == ST_FILL) & ~ts_valid
              & (idle_cnt == IW'(FLUSH_TIMEOUT));
    abort     = abort_rdy | timeout;
    mid       = (pkt_byte != 8'd0);
    kill_w    = (truncate | (abort & mid)) & wr_active;
    eff_addr  = kill_w ? base_addr : wr_addr;
    write_ok  = good_start & (state == ST_FILL) & buf_in_ready
              & (eff_addr <= ROOM_MAX);
    wr_byte   = write_ok | (cont & wr_active);
    pkt_done  = last & wr_active;
    drop_inc  = {1'b0, kill_w} + {1'b0, good_start & ~write_ok};
    drop_sum  = {1'b0, drop_cnt} + 17'(drop_inc);
  end

  // Buffer fill / commit handshake sequencing.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_WAIT_RDY: if (buf_in_ready) state_n = ST_FILL;
      ST_FILL: begin
        if (abort_rdy)
          state_n = (eff_addr != 11'd0) ? ST_COMMIT : ST_WAIT_RDY;
        else if (timeout & ~mid & (wr_addr >= ONE_PKT))
          state_n = ST_COMMIT;
        else if (pkt_done & (pkt_cnt == 4'(PPC - 1)))
          state_n = ST_COMMIT;
      end
      ST_COMMIT:
        if (buf_in_commit & buf_in_commit_ack) state_n = ST_ACK_LOW;
      ST_ACK_LOW:
        if (~buf_in_commit_ack) state_n = ST_WAIT_RDY;
      default: state_n = ST_WAIT_RDY;
    endcase
  end

  // State register.
  always_ff @(posedge ext_clk) begin
    if (reset) state <= ST_WAIT_RDY;
    else       state <= state_n;
  end

  // Registered write port, commit request, counters and address tracking.
  always_ff @(posedge ext_clk) begin
    if (reset) begin
      buf_in_addr       <= 11'd0;
      buf_in_data       <= 8'd0;
      buf_in_wren       <= 1'b0;
      buf_in_commit     <= 1'b0;
      buf_in_commit_len <= 11'd0;
      drop_cnt          <= 16'd0;
      sync_err          <= 1'b0;
      wr_addr           <= 11'd0;
      base_addr         <= 11'd0;
      pkt_cnt           <= 4'd0;
      wr_active         <= 1'b0;
      idle_cnt          <= '0;
    end else begin
      buf_in_wren <= wr_byte;
      if (wr_byte) begin
        buf_in_addr <= eff_addr;
        buf_in_data <= ts_data;
      end
      sync_err      <= err;
      buf_in_commit <= (state == ST_COMMIT)
                     & ~(buf_in_commit & buf_in_commit_ack);
      if (state == ST_COMMIT) buf_in_commit_len <= wr_addr;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (state == ST_WAIT_RDY) begin
        wr_addr   <= 11'd0;
        base_addr <= 11'd0;
        pkt_cnt   <= 4'd0;
        wr_active <= 1'b0;
      end else begin
        wr_addr <= wr_byte ? eff_addr + 11'd1 : eff_addr;
        if (write_ok) base_addr <= eff_addr;
        if (write_ok)            wr_active <= 1'b1;
        else if (kill_w | pkt_done) wr_active <= 1'b0;
        if (pkt_done) pkt_cnt <= pkt_cnt + 4'd1;
      end
      if ((state != ST_FILL) | ts_valid | (timeout & mid))
        idle_cnt <= '0;
      else if (idle_cnt != IW'(FLUSH_TIMEOUT))
        idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: doc/usb2_ts_packer.md
# usb2_ts_packer

Transport-stream packer in the EP3 ingest path, clocked by the demodulator-side clock. Aligns an incoming byte-wide TS stream on 188-byte packet boundaries and writes whole packets into the EP3 isochronous IN endpoint buffer through its external write port. Commits a buffer after a programmable packet count or an idle timeout. Packets arriving while the endpoint buffer is unavailable are dropped whole and counted.

## Interface
- PKTS_PER_COMMIT, 5, packets per committed buffer; legal range 1..10, so that 188*N ≤ 2047.
- FLUSH_TIMEOUT, 4096, idle cycles after which a partial buffer holding at least one whole packet is committed; 0 disables the timeout.
- ext_clk  in  1  sole clock (EP3 write clock).
- reset  in  1  reset; synchronous, active-high.
- ts_data  in  8  TS byte.
- ts_valid  in  1  ts_data is valid this cycle.
- ts_start  in  1  with ts_valid, marks the first byte of a packet.
- buf_in_addr  out  11  EP3 buffer write address.
- buf_in_data  out  8  EP3 buffer write data.
- buf_in_wren  out  1  EP3 buffer write strobe.
- buf_in_ready  in  1  EP3 buffer free to fill.
- buf_in_commit  out  1  commit request.
- buf_in_commit_len  out  11  committed byte count, 188*k.
- buf_in_commit_ack  in  1  commit accepted.
- drop_cnt  out  16  packets dropped; saturates at 16'hFFFF.
- sync_err  out  1  one-cycle pulse on a malformed packet.

## Operation
- There is no backpressure on the TS input; every valid byte is either written or discarded.
- **Packet acceptance:** a packet starts on ts_valid & ts_start & ts_data==8'h47.
  - Start flagged with any other data: pulse sync_err and discard up to the next start.
- **Byte counter:** pkt_byte, 0..187, counts bytes within the current packet.
  - A new ts_start while pkt_byte≠0 truncates the packet. The truncated packet is dropped: pulse sync_err, rewind the write address to the packet's base, increment drop_cnt.
  - The new start is then evaluated normally in the same cycle.
- **Write decision:** made at packet start.
  - The packet is written only if state is ST_FILL and the buffer has room for 188 more bytes.
  - Otherwise the whole packet is discarded and drop_cnt increments once, at its start byte.
- **States:**
  - ST_WAIT_RDY: wait for buf_in_ready=1, then go to ST_FILL with wr_addr=0.
  - ST_FILL: write accepted bytes at wr_addr, then increment wr_addr. On the 188th byte of packet PKTS_PER_COMMIT, go to ST_COMMIT.
  - ST_COMMIT: assert buf_in_commit with buf_in_commit_len=wr_addr; hold both until buf_in_commit_ack=1, then go to ST_ACK_LOW.
  - ST_ACK_LOW: buf_in_commit=0; wait for buf_in_commit_ack=0, then go to ST_WAIT_RDY.
- **Idle timeout:** in ST_FILL, an idle counter resets on every ts_valid.
  - When it reaches FLUSH_TIMEOUT with pkt_byte==0 and wr_addr≥188, go to ST_COMMIT.
  - When it reaches FLUSH_TIMEOUT mid-packet, abandon the packet: rewind, drop, and stay in ST_FILL.
- **Ready loss:** if buf_in_ready falls during ST_FILL, the current partial packet is rewound and counted as dropped.
  - If whole packets remain in the buffer, go to ST_COMMIT; otherwise go to ST_WAIT_RDY.
- **Reset:** reset mid-operation abandons buffer contents with no commit and clears drop_cnt.

## Timing
- Reset values:
  - state ST_WAIT_RDY
  - buf_in_addr 0, buf_in_data 0
  - buf_in_wren 0, buf_in_commit 0, buf_in_commit_len 0
  - drop_cnt 0, sync_err 0
- Write path is registered: an input byte at cycle t appears on buf_in_* at t+1.
- Commit follows the last write: buf_in_commit rises at t+2 relative to the last input byte, one cycle after its wren.
- Bytes arriving in ST_COMMIT or ST_ACK_LOW belong to packets that are dropped.
- When ts_start and the final byte of a packet coincide, the truncation rule applies.
- The counter saturates: drop_cnt does not wrap.

## Structure
- Shared package usb2_ts_pkg holds:
  - TS_PKT_LEN=188 and TS_SYNC=8'h47.
  - The state enum.
  - A function computing the maximum legal PKTS_PER_COMMIT from an address width.
- One sub-module, usb2_ts_sync: packet-start qualification, pkt_byte counter, sync_err and truncate detection.

## Test plan
- PKTS_PER_COMMIT=5, 5 back-to-back good packets, ready=1, ack returned 3 cycles after commit → 940 wren writes at addresses 0..939, one commit with len=940, drop_cnt=0.
- 2 good packets then idle for FLUSH_TIMEOUT cycles → commit with len=376.
- Packet whose start byte is 8'h48 → sync_err pulses once, nothing written; the following good packet is written at addr 0.
- ts_start after 100 bytes → sync_err pulses, drop_cnt=1, wr_addr rewinds to the packet base; the next packet is written at that base.
- buf_in_ready=0 while 3 packets arrive → drop_cnt=3, no wren.
- Reset asserted mid-packet → all outputs return to their reset values the next cycle; no commit is issued.
